// File: rtl/bru_issue_queue_pkg.sv
// -----------------------------------------------------------------------------
// bru_issue_queue_pkg
//   Definitions shared by the branch issue queue and its entry sub-module.
//   - TAG_WD          : rename tag width
//   - OP_WD           : width of the one-hot branch op
//   - inst_status_t   : field layout of the packed instruction-status word
//   - INST_STATE_WD   : width of that word
//   - br_op_e         : one-hot branch op encodings, same bit order as the
//                       branch unit (beq is the MSB)
// -----------------------------------------------------------------------------
package bru_issue_queue_pkg;

   localparam int TAG_WD = 6;
   localparam int OP_WD  = 12;

   // Field slices of the instruction-status word, MSB first.
   typedef struct packed {
      logic [4:0]  wdest;   // destination register of link-type ops
      logic        we;      // writes a register (jal/jalr/bgezal/bltzal)
      logic [31:0] imm;     // sign-extended branch offset / jump target
      logic [31:0] pc;      // PC of the branch itself
   } inst_status_t;

   localparam int INST_STATE_WD = $bits(inst_status_t);

   typedef enum logic [OP_WD-1:0] {
      BR_BEQ    = 12'h800,
      BR_BNE    = 12'h400,
      BR_BGEZ   = 12'h200,
      BR_BGTZ   = 12'h100,
      BR_BLEZ   = 12'h080,
      BR_BLTZ   = 12'h040,
      BR_BGEZAL = 12'h020,
      BR_BLTZAL = 12'h010,
      BR_J      = 12'h008,
      BR_JAL    = 12'h004,
      BR_JR     = 12'h002,
      BR_JALR   = 12'h001
   } br_op_e;

endpackage

// File: rtl/bru_iq_entry.sv
// -----------------------------------------------------------------------------
// bru_iq_entry
//   One slot of the branch issue queue: op/status/pc storage plus two source
//   operands, each with its own dual-CDB tag compare and capture.
//   Ports:
//     clk, resetn          clock, asynchronous active-low reset
//     clear                flush: drops the entry
//     wr_en / enq_*        write a new op into this slot
//     rd_en                this slot is the head being issued
//     cdb0_*, cdb1_*       result broadcasts (cdb0 has priority)
//     op, inst_status,
//     pc_plus_8            stored fields
//     rs_ok/rt_ok,
//     rs_val/rt_val        operand availability and value seen by the issue mux
//   Build option: BRU_IQ_BYPASS_EN makes rs_ok/rt_ok and the values also
//   reflect a CDB hit in the current cycle.
// -----------------------------------------------------------------------------
module bru_iq_entry
   import bru_issue_queue_pkg::*;
#(
   parameter int TAG_WD        = bru_issue_queue_pkg::TAG_WD,
   parameter int INST_STATE_WD = bru_issue_queue_pkg::INST_STATE_WD
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     clear,
   input  logic                     wr_en,
   input  logic                     rd_en,
   input  logic [OP_WD-1:0]         enq_op,
   input  logic [INST_STATE_WD-1:0] enq_inst_status,
   input  logic [31:0]              enq_pc_plus_8,
   input  logic                     enq_rs_rdy,
   input  logic                     enq_rt_rdy,
   input  logic [TAG_WD-1:0]        enq_rs_tag,
   input  logic [TAG_WD-1:0]        enq_rt_tag,
   input  logic [31:0]              enq_rs_data,
   input  logic [31:0]              enq_rt_data,
   input  logic                     cdb0_valid,
   input  logic [TAG_WD-1:0]        cdb0_tag,
   input  logic [31:0]              cdb0_data,
   input  logic                     cdb1_valid,
   input  logic [TAG_WD-1:0]        cdb1_tag,
   input  logic [31:0]              cdb1_data,
   output logic [OP_WD-1:0]         op,
   output logic [INST_STATE_WD-1:0] inst_status,
   output logic [31:0]              pc_plus_8,
   output logic                     rs_ok,
   output logic                     rt_ok,
   output logic [31:0]              rs_val,
   output logic [31:0]              rt_val
);

   logic                     valid_reg, valid_next;
   logic [OP_WD-1:0]         op_reg;
   logic [INST_STATE_WD-1:0] status_reg;
   logic [31:0]              pc8_reg;

   // Operand 0 is rs, operand 1 is rt.
   logic [1:0]        src_in_rdy;
   logic [TAG_WD-1:0] src_in_tag  [2];
   logic [31:0]       src_in_data [2];
   logic [1:0]        src_ok;
   logic [31:0]       src_val [2];

   assign src_in_rdy     = {enq_rt_rdy, enq_rs_rdy};
   assign src_in_tag[0]  = enq_rs_tag;
   assign src_in_tag[1]  = enq_rt_tag;
   assign src_in_data[0] = enq_rs_data;
   assign src_in_data[1] = enq_rt_data;

   always_comb begin
      valid_next = valid_reg;
      if (clear)
         valid_next = 1'b0;
      else if (wr_en)
         valid_next = 1'b1;
      else if (rd_en)
         valid_next = 1'b0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid_reg  <= 1'b0;
         op_reg     <= '0;
         status_reg <= '0;
         pc8_reg    <= '0;
      end else begin
         valid_reg <= valid_next;
         if (wr_en) begin
            op_reg     <= enq_op;
            status_reg <= enq_inst_status;
            pc8_reg    <= enq_pc_plus_8;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         logic              rdy_reg, rdy_next;
         logic [TAG_WD-1:0] tag_reg, tag_next;
         logic [31:0]       data_reg, data_next;
         logic              enq_hit0, enq_hit1, wake_hit0, wake_hit1;

         // Incoming op compares its own tag so a same-cycle broadcast is not lost.
         assign enq_hit0  = cdb0_valid && (cdb0_tag == src_in_tag[gi]);
         assign enq_hit1  = cdb1_valid && (cdb1_tag == src_in_tag[gi]);
         assign wake_hit0 = cdb0_valid && (cdb0_tag == tag_reg);
         assign wake_hit1 = cdb1_valid && (cdb1_tag == tag_reg);

         always_comb begin
            rdy_next  = rdy_reg;
            tag_next  = tag_reg;
            data_next = data_reg;
            if (wr_en) begin
               tag_next = src_in_tag[gi];
               if (src_in_rdy[gi]) begin
                  rdy_next  = 1'b1;
                  data_next = src_in_data[gi];
               end else if (enq_hit0) begin
                  rdy_next  = 1'b1;
                  data_next = cdb0_data;
               end else if (enq_hit1) begin
                  rdy_next  = 1'b1;
                  data_next = cdb1_data;
               end else begin
                  rdy_next  = 1'b0;
                  data_next = '0;
               end
            end else if (valid_reg && !rdy_reg) begin
               if (wake_hit0) begin
                  rdy_next  = 1'b1;
                  data_next = cdb0_data;
               end else if (wake_hit1) begin
                  rdy_next  = 1'b1;
                  data_next = cdb1_data;
               end
            end
         end

         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               rdy_reg  <= 1'b0;
               tag_reg  <= '0;
               data_reg <= '0;
            end else begin
               rdy_reg  <= rdy_next;
               tag_reg  <= tag_next;
               data_reg <= data_next;
            end
         end

`ifdef BRU_IQ_BYPASS_EN
         assign src_ok[gi]  = rdy_reg || wake_hit0 || wake_hit1;
         assign src_val[gi] = rdy_reg   ? data_reg  :
                              wake_hit0 ? cdb0_data :
                              wake_hit1 ? cdb1_data : data_reg;
`else
         assign src_ok[gi]  = rdy_reg;
         assign src_val[gi] = data_reg;
`endif
      end
   endgenerate

   assign op          = op_reg;
   assign inst_status = status_reg;
   assign pc_plus_8   = pc8_reg;
   assign rs_ok       = src_ok[0];
   assign rt_ok       = src_ok[1];
   assign rs_val      = src_val[0];
   assign rt_val      = src_val[1];

endmodule

// File: rtl/bru_issue_queue.sv
// -----------------------------------------------------------------------------
// bru_issue_queue
//   In-order issue queue in front of the branch unit. Buffers decoded branch
//   ops, wakes operands from two CDB ports and issues the head once both
//   sources are available.
//   Ports:
//     clk, resetn             clock, asynchronous active-low reset
//     flush                   kills every entry, pointers return to 0
//     enq_valid/enq_ready     decode handshake (enq_ready = !full)
//     enq_*                   op, status, pc+8 and operand rdy/tag/data
//     cdb0_*, cdb1_*          result broadcasts, cdb0 wins on a double hit
//     ready                   issue strobe; op/inst_status/rdata1/rdata2/
//                             pc_plus_8 are the head fields, else all 0
//     count                   occupancy
//   Build option: BRU_IQ_BYPASS_EN lets a CDB hit in the current cycle satisfy
//   the head's issue condition (same-cycle wakeup-to-issue).
// -----------------------------------------------------------------------------
module bru_issue_queue
   import bru_issue_queue_pkg::*;
#(
   parameter int DEPTH         = 4,
   parameter int TAG_WD        = bru_issue_queue_pkg::TAG_WD,
   parameter int INST_STATE_WD = bru_issue_queue_pkg::INST_STATE_WD
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     flush,
   input  logic                     enq_valid,
   output logic                     enq_ready,
   input  logic [OP_WD-1:0]         enq_op,
   input  logic [INST_STATE_WD-1:0] enq_inst_status,
   input  logic [31:0]              enq_pc_plus_8,
   input  logic                     enq_rs_rdy,
   input  logic                     enq_rt_rdy,
   input  logic [TAG_WD-1:0]        enq_rs_tag,
   input  logic [TAG_WD-1:0]        enq_rt_tag,
   input  logic [31:0]              enq_rs_data,
   input  logic [31:0]              enq_rt_data,
   input  logic                     cdb0_valid,
   input  logic                     cdb1_valid,
   input  logic [TAG_WD-1:0]        cdb0_tag,
   input  logic [TAG_WD-1:0]        cdb1_tag,
   input  logic [31:0]              cdb0_data,
   input  logic [31:0]              cdb1_data,
   output logic                     ready,
   output logic [OP_WD-1:0]         op,
   output logic [INST_STATE_WD-1:0] inst_status,
   output logic [31:0]              rdata1,
   output logic [31:0]              rdata2,
   output logic [31:0]              pc_plus_8,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int IDX_WD = $clog2(DEPTH);
   localparam int PTR_WD = IDX_WD + 1;

   // Pointers carry one wrap bit above the index.
   logic [PTR_WD-1:0] head_reg, head_next, tail_reg, tail_next;
   logic [IDX_WD-1:0] head_idx, tail_idx;
   logic              full, empty, do_enq, do_issue;

   logic [OP_WD-1:0]         e_op     [DEPTH];
   logic [INST_STATE_WD-1:0] e_status [DEPTH];
   logic [31:0]              e_pc8    [DEPTH];
   logic [31:0]              e_rs_val [DEPTH];
   logic [31:0]              e_rt_val [DEPTH];
   logic [DEPTH-1:0]         e_rs_ok, e_rt_ok;

   assign head_idx  = head_reg[IDX_WD-1:0];
   assign tail_idx  = tail_reg[IDX_WD-1:0];
   assign full      = (head_reg[IDX_WD] != tail_reg[IDX_WD]) && (head_idx == tail_idx);
   assign empty     = (head_reg == tail_reg);
   assign enq_ready = !full;
   assign do_enq    = enq_valid && !full && !flush;
   // An empty queue never issues, so a same-cycle enqueue cannot bypass to issue.
   assign do_issue  = !empty && e_rs_ok[head_idx] && e_rt_ok[head_idx] && !flush;
   assign count     = tail_reg - head_reg;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         bru_iq_entry #(
            .TAG_WD        (TAG_WD),
            .INST_STATE_WD (INST_STATE_WD)
         ) u_entry (
            .clk             (clk),
            .resetn          (resetn),
            .clear           (flush),
            .wr_en           (do_enq && (tail_idx == IDX_WD'(gi))),
            .rd_en           (do_issue && (head_idx == IDX_WD'(gi))),
            .enq_op          (enq_op),
            .enq_inst_status (enq_inst_status),
            .enq_pc_plus_8   (enq_pc_plus_8),
            .enq_rs_rdy      (enq_rs_rdy),
            .enq_rt_rdy      (enq_rt_rdy),
            .enq_rs_tag      (enq_rs_tag),
            .enq_rt_tag      (enq_rt_tag),
            .enq_rs_data     (enq_rs_data),
            .enq_rt_data     (enq_rt_data),
            .cdb0_valid      (cdb0_valid),
            .cdb0_tag        (cdb0_tag),
            .cdb0_data       (cdb0_data),
            .cdb1_valid      (cdb1_valid),
            .cdb1_tag        (cdb1_tag),
            .cdb1_data       (cdb1_data),
            .op              (e_op[gi]),
            .inst_status     (e_status[gi]),
            .pc_plus_8       (e_pc8[gi]),
            .rs_ok           (e_rs_ok[gi]),
            .rt_ok           (e_rt_ok[gi]),
            .rs_val          (e_rs_val[gi]),
            .rt_val          (e_rt_val[gi])
         );
      end
   endgenerate

   always_comb begin
      head_next = head_reg + PTR_WD'(do_issue);
      tail_next = tail_reg + PTR_WD'(do_enq);
      if (flush) begin
         head_next = '0;
         tail_next = '0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head_reg <= '0;
         tail_reg <= '0;
      end else begin
         head_reg <= head_next;
         tail_reg <= tail_next;
      end
   end

   // The branch unit treats op == 0 as a bubble, so idle outputs are zeroed.
   always_comb begin
      ready       = do_issue;
      op          = '0;
      inst_status = '0;
      rdata1      = '0;
      rdata2      = '0;
      pc_plus_8   = '0;
      if (do_issue) begin
         op          = e_op[head_idx];
         inst_status = e_status[head_idx];
         rdata1      = e_rs_val[head_idx];
         rdata2      = e_rt_val[head_idx];
         pc_plus_8   = e_pc8[head_idx];
      end
   end

endmodule

// File: tb/tb_bru_issue_queue.sv
module tb_bru_issue_queue;
   import bru_issue_queue_pkg::*;

   localparam int DEPTH = 4;
   localparam int SW    = INST_STATE_WD;
`ifdef BRU_IQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          flush, enq_valid, enq_ready;
   logic [11:0]   enq_op;
   logic [SW-1:0] enq_inst_status;
   logic [31:0]   enq_pc_plus_8;
   logic          enq_rs_rdy, enq_rt_rdy;
   logic [5:0]    enq_rs_tag, enq_rt_tag;
   logic [31:0]   enq_rs_data, enq_rt_data;
   logic          cdb0_valid, cdb1_valid;
   logic [5:0]    cdb0_tag, cdb1_tag;
   logic [31:0]   cdb0_data, cdb1_data;
   logic          ready;
   logic [11:0]   op;
   logic [SW-1:0] inst_status;
   logic [31:0]   rdata1, rdata2, pc_plus_8;
   logic [2:0]    count;

   always #5 clk = ~clk;

   bru_issue_queue #(.DEPTH(DEPTH), .TAG_WD(6), .INST_STATE_WD(SW)) dut (
      .clk(clk), .resetn(resetn), .flush(flush),
      .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_op(enq_op),
      .enq_inst_status(enq_inst_status), .enq_pc_plus_8(enq_pc_plus_8),
      .enq_rs_rdy(enq_rs_rdy), .enq_rt_rdy(enq_rt_rdy),
      .enq_rs_tag(enq_rs_tag), .enq_rt_tag(enq_rt_tag),
      .enq_rs_data(enq_rs_data), .enq_rt_data(enq_rt_data),
      .cdb0_valid(cdb0_valid), .cdb1_valid(cdb1_valid),
      .cdb0_tag(cdb0_tag), .cdb1_tag(cdb1_tag),
      .cdb0_data(cdb0_data), .cdb1_data(cdb1_data),
      .ready(ready), .op(op), .inst_status(inst_status),
      .rdata1(rdata1), .rdata2(rdata2), .pc_plus_8(pc_plus_8), .count(count)
   );

   typedef struct packed {
      logic          flush, enq_valid;
      logic [11:0]   op;
      logic [SW-1:0] st;
      logic [31:0]   pc8;
      logic          rs_rdy, rt_rdy;
      logic [5:0]    rs_tag, rt_tag;
      logic [31:0]   rs_data, rt_data;
      logic          c0v;
      logic [5:0]    c0t;
      logic [31:0]   c0d;
      logic          c1v;
      logic [5:0]    c1t;
      logic [31:0]   c1d;
   } in_t;

   typedef struct packed {
      logic [11:0]   op;
      logic [SW-1:0] st;
      logic [31:0]   pc8;
      logic          rs_rdy, rt_rdy;
      logic [5:0]    rs_tag, rt_tag;
      logic [31:0]   rs_data, rt_data;
   } ent_t;

   typedef struct {
      in_t         in;
      logic        ready;
      logic [11:0] op;
      logic [31:0] r1, r2;
      int          cnt;
      logic        erdy;
   } vec_t;

   // Reference model: program-order list of buffered ops.
   ent_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;

   logic          m_ready, m_erdy;
   logic [11:0]   m_op;
   logic [SW-1:0] m_st;
   logic [31:0]   m_pc8, m_r1, m_r2;
   int            m_cnt;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic in_t idle_in();
      in_t v;
      v = '0;
      return v;
   endfunction

   function automatic in_t mk_enq(logic [11:0] o, logic rsr, logic [5:0] rst, logic [31:0] rsd,
                                  logic rtr, logic [5:0] rtt, logic [31:0] rtd);
      in_t v;
      v = '0;
      v.enq_valid = 1'b1;
      v.op = o;
      v.st = SW'({$urandom(), $urandom(), $urandom()});
      v.pc8 = $urandom();
      v.rs_rdy = rsr; v.rs_tag = rst; v.rs_data = rsd;
      v.rt_rdy = rtr; v.rt_tag = rtt; v.rt_data = rtd;
      return v;
   endfunction

   function automatic in_t mk_cdb(logic v0, logic [5:0] t0, logic [31:0] d0,
                                  logic v1, logic [5:0] t1, logic [31:0] d1);
      in_t v;
      v = '0;
      v.c0v = v0; v.c0t = t0; v.c0d = d0;
      v.c1v = v1; v.c1t = t1; v.c1d = d1;
      return v;
   endfunction

   // Operand after a cycle of CDB observation: {ready, data}; cdb0 first.
   function automatic logic [32:0] grab(logic rdy, logic [5:0] tag, logic [31:0] data, in_t v);
      if (rdy) return {1'b1, data};
      if (v.c0v && v.c0t == tag) return {1'b1, v.c0d};
      if (v.c1v && v.c1t == tag) return {1'b1, v.c1d};
      return {1'b0, data};
   endfunction

   // Operand as seen by the issue decision this cycle.
   function automatic logic [32:0] src_now(logic rdy, logic [5:0] tag, logic [31:0] data, in_t v);
      if (BYP) return grab(rdy, tag, data, v);
      return {rdy, data};
   endfunction

   task automatic model_eval(input in_t v);
      logic [32:0] s1, s2;
      m_ready = 1'b0; m_op = '0; m_st = '0; m_pc8 = '0; m_r1 = '0; m_r2 = '0;
      m_cnt  = q.size();
      m_erdy = (q.size() < DEPTH);
      if (q.size() > 0 && !v.flush) begin
         s1 = src_now(q[0].rs_rdy, q[0].rs_tag, q[0].rs_data, v);
         s2 = src_now(q[0].rt_rdy, q[0].rt_tag, q[0].rt_data, v);
         if (s1[32] && s2[32]) begin
            m_ready = 1'b1;
            m_op = q[0].op; m_st = q[0].st; m_pc8 = q[0].pc8;
            m_r1 = s1[31:0]; m_r2 = s2[31:0];
         end
      end
   endtask

   task automatic model_step(input in_t v);
      ent_t e;
      bit   accept;
      accept = v.enq_valid && (q.size() < DEPTH);
      if (v.flush) begin
         q.delete();
      end else begin
         if (m_ready) void'(q.pop_front());
         foreach (q[i]) begin
            e = q[i];
            {e.rs_rdy, e.rs_data} = grab(e.rs_rdy, e.rs_tag, e.rs_data, v);
            {e.rt_rdy, e.rt_data} = grab(e.rt_rdy, e.rt_tag, e.rt_data, v);
            q[i] = e;
         end
         if (accept) begin
            e.op = v.op; e.st = v.st; e.pc8 = v.pc8;
            e.rs_tag = v.rs_tag; e.rt_tag = v.rt_tag;
            {e.rs_rdy, e.rs_data} = grab(v.rs_rdy, v.rs_tag, v.rs_data, v);
            {e.rt_rdy, e.rt_data} = grab(v.rt_rdy, v.rt_tag, v.rt_data, v);
            q.push_back(e);
         end
      end
   endtask

   task automatic drive(input in_t v);
      flush = v.flush; enq_valid = v.enq_valid; enq_op = v.op;
      enq_inst_status = v.st; enq_pc_plus_8 = v.pc8;
      enq_rs_rdy = v.rs_rdy; enq_rt_rdy = v.rt_rdy;
      enq_rs_tag = v.rs_tag; enq_rt_tag = v.rt_tag;
      enq_rs_data = v.rs_data; enq_rt_data = v.rt_data;
      cdb0_valid = v.c0v; cdb0_tag = v.c0t; cdb0_data = v.c0d;
      cdb1_valid = v.c1v; cdb1_tag = v.c1t; cdb1_data = v.c1d;
   endtask

   // One clock: drive after the falling edge, check mid-cycle, advance model.
   task automatic cycle(input in_t v);
      @(negedge clk);
      drive(v);
      #1;
      model_eval(v);
      chk("ready", ready, m_ready);
      chk("op", op, m_op);
      chk("inst_status", inst_status, m_st);
      chk("pc_plus_8", pc_plus_8, m_pc8);
      chk("rdata1", rdata1, m_r1);
      chk("rdata2", rdata2, m_r2);
      chk("count", count, m_cnt);
      chk("enq_ready", enq_ready, m_erdy);
      if (m_ready)
         $display("issue op=%03h rdata1=%08h rdata2=%08h pc_plus_8=%08h count=%0d",
                  op, rdata1, rdata2, pc_plus_8, count);
      model_step(v);
   endtask

   vec_t tbl [10];

   task automatic set_vec(input int i, input in_t in, input logic r, input logic [11:0] o,
                          input logic [31:0] r1, input logic [31:0] r2, input int c, input logic er);
      tbl[i].in = in; tbl[i].ready = r; tbl[i].op = o;
      tbl[i].r1 = r1; tbl[i].r2 = r2; tbl[i].cnt = c; tbl[i].erdy = er;
   endtask

   initial begin
      in_t v;
      int  n_iss, first, last;
      bit  got;

      drive(idle_in());
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", ready, 1'b0);
      chk("rst_op", op, 12'h0);
      chk("rst_rdata1", rdata1, 32'h0);
      chk("rst_rdata2", rdata2, 32'h0);
      chk("rst_pc_plus_8", pc_plus_8, 32'h0);
      chk("rst_count", count, 3'd0);
      chk("rst_enq_ready", enq_ready, 1'b1);
      @(negedge clk);
      resetn = 1'b1;

      // Directed table: beq with ready operands, then bne woken by cdb1.
      set_vec(0, idle_in(), 1'b0, 12'h000, 32'h0, 32'h0, 0, 1'b1);
      set_vec(1, mk_enq(12'h800, 1'b1, 6'd0, 32'h5, 1'b1, 6'd0, 32'h5),
              1'b0, 12'h000, 32'h0, 32'h0, 0, 1'b1);
      set_vec(2, idle_in(), 1'b1, 12'h800, 32'h5, 32'h5, 1, 1'b1);
      set_vec(3, idle_in(), 1'b0, 12'h000, 32'h0, 32'h0, 0, 1'b1);
      set_vec(4, mk_enq(12'h400, 1'b0, 6'd9, 32'h0, 1'b1, 6'd0, 32'h7),
              1'b0, 12'h000, 32'h0, 32'h0, 0, 1'b1);
      set_vec(5, idle_in(), 1'b0, 12'h000, 32'h0, 32'h0, 1, 1'b1);
      set_vec(6, idle_in(), 1'b0, 12'h000, 32'h0, 32'h0, 1, 1'b1);
      set_vec(7, mk_cdb(1'b0, 6'd0, 32'h0, 1'b1, 6'd9, 32'h1234),
              BYP, BYP ? 12'h400 : 12'h000, BYP ? 32'h1234 : 32'h0, BYP ? 32'h7 : 32'h0, 1, 1'b1);
      set_vec(8, idle_in(), !BYP, BYP ? 12'h000 : 12'h400, BYP ? 32'h0 : 32'h1234,
              BYP ? 32'h0 : 32'h7, BYP ? 0 : 1, 1'b1);
      set_vec(9, idle_in(), 1'b0, 12'h000, 32'h0, 32'h0, 0, 1'b1);

      for (int i = 0; i < 10; i++) begin
         cycle(tbl[i].in);
         chk($sformatf("tbl%0d_ready", i), ready, tbl[i].ready);
         chk($sformatf("tbl%0d_op", i), op, tbl[i].op);
         chk($sformatf("tbl%0d_rdata1", i), rdata1, tbl[i].r1);
         chk($sformatf("tbl%0d_rdata2", i), rdata2, tbl[i].r2);
         chk($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
         chk($sformatf("tbl%0d_enq_ready", i), enq_ready, tbl[i].erdy);
      end

      // Fill with the head blocked on tag 3; fifth enqueue must be refused.
      for (int k = 0; k < 4; k++)
         cycle(mk_enq(12'h001 << k, 1'b0, 6'd3, 32'h0, 1'b1, 6'd0, 32'h100 + k));
      cycle(mk_enq(12'h800, 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 32'h2));
      chk("full_enq_ready", enq_ready, 1'b0);
      chk("full_count", count, 3'd4);
      n_iss = 0; first = -1; last = -1;
      for (int c = 0; c < 10 && n_iss < 4; c++) begin
         cycle(c == 0 ? mk_cdb(1'b1, 6'd3, 32'hAAAA, 1'b0, 6'd0, 32'h0) : idle_in());
         if (ready) begin
            chk("inorder_op", op, 12'h001 << n_iss);
            if (first < 0) first = c;
            last = c;
            n_iss++;
         end
      end
      chk("drain_issued", n_iss, 4);
      chk("drain_back_to_back", last - first, 3);
      cycle(idle_in());

      // Both CDBs hit the same tag: cdb0 data must be captured.
      cycle(mk_enq(12'h200, 1'b0, 6'd7, 32'h0, 1'b1, 6'd0, 32'h55));
      got = 1'b0;
      for (int c = 0; c < 4 && !got; c++) begin
         cycle(c == 0 ? mk_cdb(1'b1, 6'd7, 32'hA0A0_0001, 1'b1, 6'd7, 32'hB0B0_0002) : idle_in());
         if (ready) begin
            got = 1'b1;
            chk("cdb0_priority", rdata1, 32'hA0A0_0001);
         end
      end
      chk("dual_cdb_issue_seen", got, 1'b1);
      cycle(idle_in());

      // Flush with a same-cycle enqueue while three entries are valid.
      for (int k = 0; k < 3; k++)
         cycle(mk_enq(12'h040, 1'b0, 6'd20, 32'h0, 1'b1, 6'd0, 32'h9));
      cycle(mk_cdb(1'b0, 6'd0, 32'h0, 1'b1, 6'd20, 32'h77));
      v = mk_enq(12'h001, 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 32'h1);
      v.flush = 1'b1;
      cycle(v);
      chk("flush_cycle_ready", ready, 1'b0);
      cycle(idle_in());
      chk("post_flush_count", count, 3'd0);
      chk("post_flush_ready", ready, 1'b0);
      chk("post_flush_op", op, 12'h000);

      // Asynchronous reset in the middle of a cycle with an issuing head.
      for (int k = 0; k < 3; k++)
         cycle(mk_enq(12'h008, 1'b0, 6'd30, 32'h0, 1'b1, 6'd0, 32'h3));
      cycle(mk_cdb(1'b1, 6'd30, 32'hCAFE, 1'b0, 6'd0, 32'h0));
      cycle(idle_in());
      chk("pre_reset_ready", ready, 1'b1);
      #2;
      resetn = 1'b0;
      #1;
      chk("async_rst_ready", ready, 1'b0);
      chk("async_rst_op", op, 12'h000);
      chk("async_rst_rdata1", rdata1, 32'h0);
      chk("async_rst_count", count, 3'd0);
      chk("async_rst_enq_ready", enq_ready, 1'b1);
      q.delete();
      @(negedge clk);
      resetn = 1'b1;

      // Randomized traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 1) == 1)
            v = mk_enq(12'h001 << $urandom_range(0, 11),
                       $urandom_range(0, 2) == 0, 6'($urandom_range(0, 7)), $urandom(),
                       $urandom_range(0, 2) == 0, 6'($urandom_range(0, 7)), $urandom());
         else
            v = idle_in();
         v.c0v = $urandom_range(0, 1) == 1; v.c0t = 6'($urandom_range(0, 7)); v.c0d = $urandom();
         v.c1v = $urandom_range(0, 1) == 1; v.c1t = 6'($urandom_range(0, 7)); v.c1d = $urandom();
         v.flush = $urandom_range(0, 39) == 0;
         cycle(v);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/bru_issue_queue.md
Name: bru_issue_queue

Overview:
In-order issue queue that feeds the branch functional unit. It buffers decoded branch/jump ops and their operand tags. It captures operands from two result-broadcast (CDB) ports and releases the head entry to the branch unit once both source operands are present. The issue outputs drive the branch unit's ready/op/inst_status/rdata1/rdata2/pc_plus_8 inputs directly; the branch unit registers them on its side.

Parameters:
DEPTH, 4, number of entries; power of two, at least 2
TAG_WD, 6, physical/rename tag width
INST_STATE_WD, from shared defines, width of the packed instruction-status word

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
flush  in  1  pipeline flush (branch mispredict / exception); kills all entries
enq_valid  in  1  decode presents a branch op
enq_ready  out  1  queue can accept; equals !full
enq_op  in  12  one-hot branch op, same bit order as the branch unit
enq_inst_status  in  INST_STATE_WD  packed status (PC, IMM, WE, ...)
enq_pc_plus_8  in  32  predicted next-fetch address after the delay slot
enq_rs_rdy, enq_rt_rdy  in  1 each  operand already available
enq_rs_tag, enq_rt_tag  in  TAG_WD each  producer tags when not ready
enq_rs_data, enq_rt_data  in  32 each  operand values when ready
cdb0_valid, cdb1_valid  in  1 each  broadcast valid
cdb0_tag, cdb1_tag  in  TAG_WD each  broadcast tag
cdb0_data, cdb1_data  in  32 each  broadcast value
ready  out  1  issue strobe to the branch unit
op  out  12  issued op
inst_status  out  INST_STATE_WD  issued status
rdata1, rdata2  out  32 each  issued rs/rt values
pc_plus_8  out  32  issued predicted address
count  out  log2(DEPTH)+1  occupancy

Behaviour:
- Clock and reset: single clock `clk`. Reset is `resetn`, asynchronous, active-low; every register clears on the falling edge of `resetn`, independent of `clk`.
- Reset state: head = tail = 0, count = 0, all entry valid bits 0, enq_ready = 1, ready = 0. op, inst_status, rdata1, rdata2 and pc_plus_8 are all 0.
- Pointers: head and tail are log2(DEPTH)+1 bits; the extra bit is a wrap bit.
  - full = (head[msb] != tail[msb]) && (low bits equal).
  - empty = (head == tail).
- Enqueue: when enq_valid && enq_ready && !flush, the tail entry is written and tail increments on the clock edge. enq_ready depends only on full, never on a same-cycle issue.
- Wakeup: every cycle, each valid entry's not-ready operand compares its tag against both CDBs. On a match, the entry latches the data and sets the ready bit. If both CDBs match, cdb0 wins.
- Enqueue-cycle capture: an operand enqueued not-ready whose tag matches a CDB in the same cycle is stored ready, with the CDB data.
- Issue: combinational from the head entry. ready = !empty && head.rs_rdy && head.rt_rdy && !flush. When ready = 1, op/inst_status/rdata1/rdata2/pc_plus_8 show the head fields and head increments at the edge. When ready = 0, all data outputs are driven to 0, because the branch unit treats op = 0 as a bubble.
- Issue rate: at most one issue per cycle, strictly in program order. A not-ready head blocks younger entries.
- Wakeup latency: without the optional feature, an operand delivered by CDB in cycle N allows issue in cycle N+1 at the earliest.
- Simultaneous enqueue and issue: both take effect; count is unchanged.
  - When full, enqueue is refused even if the head issues in the same cycle.
  - When empty, a same-cycle enqueue does not issue in that cycle (no enqueue-to-issue bypass).
- Flush: on the edge where flush = 1, all valid bits clear and head = tail = 0. ready is 0 during the flush cycle and enqueue is ignored. The next cycle behaves as post-reset.
- Pointer wrap: the index wraps modulo DEPTH and the wrap bit toggles. count = tail - head, modulo 2*DEPTH.

Optional Feature:
BRU_IQ_BYPASS_EN
- Defined: the head's issue condition also counts an operand ready when its tag matches a valid CDB in the current cycle. The issued rdata uses that CDB value, with the same cdb0 priority. Wakeup-to-issue becomes same-cycle.
- Undefined: issue uses stored ready bits only, giving one cycle of wakeup latency. Timing is shorter because no CDB compare sits on the ready path.

Decomposition:
- Shared defines: INST_STATE_WD and its field slices (PC, IMM, WE), the 12-bit branch-op bit order, and TAG_WD.
- One natural sub-module, bru_iq_entry: holds one entry's storage plus the dual-CDB tag-compare and capture logic. It is instantiated DEPTH times.
- Pointer, full/empty and issue-mux logic stay in the top module.

Test Plan:
- Reset then enqueue beq with both operands ready (rs = rt = 32'h5) -> ready = 1 on the next cycle; op = 12'h800, rdata1 = rdata2 = 32'h5; count returns to 0.
- Enqueue bne with rs not ready (tag 6'd9); cdb1 broadcasts tag 9, data 32'h1234 two cycles later -> ready = 1 one cycle after the broadcast, rdata1 = 32'h1234. With BRU_IQ_BYPASS_EN, ready = 1 in the broadcast cycle itself.
- Fill 4 entries with the head blocked (tag 6'd3) -> enq_ready = 0 and a fifth enqueue is dropped. Broadcast tag 3 -> entries issue in order on consecutive cycles, and the younger entries' tags are pre-woken.
- Both CDBs broadcast tag 6'd7 with data A/B while an entry waits on tag 7 -> the entry captures cdb0's data A.
- 3 valid entries, flush = 1 in the same cycle as enq_valid -> next cycle count = 0, ready = 0, and the new op was not stored.
- Assert resetn = 0 mid-clock while entries are valid -> outputs go to 0 immediately, without waiting for a clock edge; enq_ready = 1.
